// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin front end that lets requesters A and B share one 4x4 multiplier.
// Latency: the result is valid CALC_CYCLES edges after the accept edge and is held until taken.
// Backpressure: no operand is accepted outside IDLE; res_ready low keeps the result in HOLD.

// mult4x4: unsigned 4x4 shift-and-add multiplier, purely combinational.
// Latency: none; the caller provides settle time.
// Backpressure: none.
module mult4x4 (
    input  logic [3:0] i_x,
    input  logic [3:0] i_y,
    output logic [7:0] o_p
);
    logic [7:0] w_pp0;
    logic [7:0] w_pp1;
    logic [7:0] w_pp2;
    logic [7:0] w_pp3;

    // One partial product per multiplier bit, each pre-shifted into place.
    assign w_pp0 = i_y[0] ? {4'd0, i_x}       : 8'd0;
    assign w_pp1 = i_y[1] ? {3'd0, i_x, 1'b0} : 8'd0;
    assign w_pp2 = i_y[2] ? {2'd0, i_x, 2'b0} : 8'd0;
    assign w_pp3 = i_y[3] ? {1'b0, i_x, 3'b0} : 8'd0;

    // The largest product, 15*15 = 225, fits in 8 bits, so nothing is lost in the sum.
    assign o_p = w_pp0 + w_pp1 + w_pp2 + w_pp3;
endmodule

module mult_arbiter #(
    parameter int unsigned CALC_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       a_valid,
    output logic       a_ready,
    input  logic [3:0] a_x,
    input  logic [3:0] a_y,
    input  logic       b_valid,
    output logic       b_ready,
    input  logic [3:0] b_x,
    input  logic [3:0] b_y,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_p,
    output logic       res_id,
    output logic       busy
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // The counter starts at CALC_CYCLES-1 so that the product is captured on the
    // CALC_CYCLES-th edge after the accept edge.
    localparam logic [3:0] CNT_INIT = 4'(CALC_CYCLES - 1);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] r_op_x;
    logic [3:0] r_op_y;
    logic       r_last_grant;   // 0 = A was served last, 1 = B was served last
    logic       r_res_valid;
    logic [7:0] r_res_p;
    logic       r_res_id;

    logic       w_idle;
    logic       w_grant_a;
    logic       w_grant_b;
    logic       w_accept;
    logic       w_cnt_zero;
    logic [3:0] w_sel_x;
    logic [3:0] w_sel_y;
    logic [7:0] w_prod;

    // The shared multiplier sees only registered operands, so its inputs stay stable through CALC.
    mult4x4 u_mult (
        .i_x (r_op_x),
        .i_y (r_op_y),
        .o_p (w_prod)
    );

    assign w_idle     = (r_state == S_IDLE);
    assign w_cnt_zero = (r_cnt == 4'd0);

    // Grant is recomputed every IDLE cycle from the current valids. On a tie, the
    // requester that was not served last wins. rst_n gates the readies so they
    // stay low while reset is held.
    always_comb begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        if (w_idle && rst_n) begin
            w_grant_a = a_valid && (!b_valid || r_last_grant);
            w_grant_b = b_valid && (!a_valid || !r_last_grant);
        end
    end

    assign w_accept = w_grant_a || w_grant_b;
    assign w_sel_x  = w_grant_b ? b_x : a_x;
    assign w_sel_y  = w_grant_b ? b_y : a_y;

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: accept -> CALC, counter expiry -> HOLD, consumer handshake -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept)   w_state_nxt = S_CALC;
            S_CALC:  if (w_cnt_zero) w_state_nxt = S_HOLD;
            S_HOLD:  if (res_ready)  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Operand capture and arbitration history; these change only on an accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_x       <= 4'd0;
            r_op_y       <= 4'd0;
            r_res_id     <= 1'b0;
            r_last_grant <= 1'b1;   // reset to B so that A wins the first tie
        end else if (w_accept) begin
            r_op_x       <= w_sel_x;
            r_op_y       <= w_sel_y;
            r_res_id     <= w_grant_b;
            r_last_grant <= w_grant_b;
        end
    end

    // Settle counter: load on accept, count down while in CALC, and hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= CNT_INIT;
        end else if ((r_state == S_CALC) && !w_cnt_zero) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Result register: capture the product when the counter expires, then hold it
    // until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_valid <= 1'b0;
            r_res_p     <= 8'd0;
        end else if ((r_state == S_CALC) && w_cnt_zero) begin
            r_res_valid <= 1'b1;
            r_res_p     <= w_prod;
        end else if ((r_state == S_HOLD) && res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    assign a_ready   = w_grant_a;
    assign b_ready   = w_grant_b;
    assign res_valid = r_res_valid;
    assign res_p     = r_res_p;
    assign res_id    = r_res_id;
    assign busy      = !w_idle;
endmodule

// File: doc/mult_arbiter.md
MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter CALC_CYCLES, default 2: multiplier settle time in clock cycles, legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 a_valid  input  1  requester A operand pair valid.
REQ-005 a_ready  output  1  requester A operands accepted this cycle.
REQ-006 a_x, a_y  input  4 each  requester A unsigned operands.
REQ-007 b_valid  input  1  requester B operand pair valid.
REQ-008 b_ready  output  1  requester B operands accepted this cycle.
REQ-009 b_x, b_y  input  4 each  requester B unsigned operands.
REQ-010 res_valid  output  1  result available.
REQ-011 res_ready  input  1  consumer accepts result.
REQ-012 res_p  output  8  unsigned product.
REQ-013 res_id  output  1  source of result: 0 = A, 1 = B.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 The block shall share one instance of the team's 4x4 combinational multiplier between A and B; operand inputs to it come only from internal operand registers.
REQ-016 FSM states: IDLE, CALC, HOLD; state register is one-hot or binary, implementer's choice.
REQ-017 IDLE grant: only A valid -> A; only B valid -> B; both valid -> the requester not granted last (round-robin via last_grant register).
REQ-018 x_ready shall be combinational: high only in IDLE, only for the granted requester, never both high in one cycle.
REQ-019 On valid & ready: latch x, y into operand registers, latch res_id, set last_grant to the granted requester, load cycle counter with CALC_CYCLES-1, go to CALC.
REQ-020 IDLE with no valid: stay IDLE, no register updates.
REQ-021 CALC: counter decrements by 1 each cycle; in the cycle counter = 0, register multiplier output into res_p, set res_valid, go to HOLD.
REQ-022 Latency: accept at edge N -> res_valid high after edge N+CALC_CYCLES; with CALC_CYCLES=1, the cycle after accept.
REQ-023 HOLD: res_valid, res_p, res_id stable until res_ready; on res_valid & res_ready, clear res_valid, go to IDLE next edge.
REQ-024 No acceptance in CALC or HOLD; res_ready outside HOLD shall be ignored; max throughput one op per CALC_CYCLES+2 cycles.
REQ-025 Product is exact unsigned 8-bit; 15*15 = 225 without overflow.
REQ-026 Requester deasserting valid before grant shall not be serviced; grant recomputed every IDLE cycle from current valids.
REQ-027 Starvation bound: a continuously valid requester is accepted within two operations.

Reset
REQ-028 rst_n low shall immediately force: state IDLE, res_valid 0, res_p 0, res_id 0, counter 0, operand regs 0, last_grant = B (A wins first tie).
REQ-029 Assertion mid-CALC or mid-HOLD shall discard the operation; no result produced after release.
REQ-030 a_ready, b_ready, busy shall be 0 while rst_n is low.

Verification
REQ-031 CALC_CYCLES=2; A only, a_x=3, a_y=5 -> a_ready one cycle, res_valid 2 edges later, res_p=15, res_id=0.
REQ-032 A and B valid every cycle from reset, res_ready=1 -> results alternate id 0,1,0,1; first is A.
REQ-033 B: b_x=15, b_y=15, res_ready held 0 for 5 cycles -> res_p=225, res_id=1 stable 5 cycles; no ready to A or B during hold.
REQ-034 Operand 0 x 9 from A -> res_p=0; a_x=1, a_y=1 -> res_p=1.
REQ-035 rst_n low in CALC cycle 1 -> res_valid never rises, outputs zero, next accept is fresh and A-prioritised.
REQ-036 CALC_CYCLES=1 and 15 sweep, all 256 operand pairs alternating requesters -> every res_p equals x*y, correct res_id, latency exact.
